// File: rtl/ff_bank_pkg.sv
// Shared types and default constants for the two-requester register arbiter.
package ff_bank_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned HOLD_MAX_DEF = 4;
  // Hold counter width; covers HOLD_MAX up to 15
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

endpackage

// File: rtl/ff_word.sv
// WIDTH-bit storage word: async clear, load enable, optional sync clear
// (sync clear present only when SYNC_CLR_EN is defined).
module ff_word
  import ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rc,
  input  logic             ld,
`ifdef SYNC_CLR_EN
  input  logic             sc,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Sync clear beats load; async clear beats everything
  always_ff @(posedge clk or posedge rc) begin
    if (rc) begin
      q <= '0;
`ifdef SYNC_CLR_EN
    end else if (sc) begin
      q <= '0;
`endif
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ff_bank_arb.sv
// Two-requester arbiter owning a shared register, with hold-time preemption.
// Optional synchronous clear port sc enabled by defining SYNC_CLR_EN.
module ff_bank_arb
  import ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rc,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
`ifdef SYNC_CLR_EN
  input  logic             sc,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             last;      // index of the requester served most recently
  logic             hold_done_c;
  logic             ld_c;
  logic [WIDTH-1:0] wdata_c;

  // Counter value including the current granted edge, saturating
  assign cnt_inc_c   = (cnt >= CNT_W'(HOLD_MAX)) ? cnt : cnt + CNT_W'(1);
  assign hold_done_c = (cnt_inc_c == CNT_W'(HOLD_MAX));

  // Owner writes on every edge it still requests, including a preempting edge
  assign ld_c    = ((state == G0) && req0) || ((state == G1) && req1);
  assign wdata_c = (state == G1) ? d1 : d0;

  // Arbitration FSM with registered grants, busy and hold counter
  always_ff @(posedge clk or posedge rc) begin
    if (rc) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= 1'b1;
`ifdef SYNC_CLR_EN
    end else if (sc) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            state <= G0;
            gnt0  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (req1) begin
            state <= G1;
            gnt1  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        G0: begin
          if (!req0) begin
            last <= 1'b0;
            gnt0 <= 1'b0;
            cnt  <= '0;
            if (req1) begin
              state <= G1;
              gnt1  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (req1 && hold_done_c) begin
            last  <= 1'b0;
            state <= G1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        G1: begin
          if (!req1) begin
            last <= 1'b1;
            gnt1 <= 1'b0;
            cnt  <= '0;
            if (req0) begin
              state <= G0;
              gnt0  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (req0 && hold_done_c) begin
            last  <= 1'b1;
            state <= G0;
            gnt1  <= 1'b0;
            gnt0  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shared register
  ff_word #(
    .WIDTH(WIDTH)
  ) u_word (
    .clk (clk),
    .rc  (rc),
    .ld  (ld_c),
`ifdef SYNC_CLR_EN
    .sc  (sc),
`endif
    .d   (wdata_c),
    .q   (q)
  );

endmodule

// File: doc/ff_bank_arb.md
FF_BANK_ARB -- requirements
Module: ff_bank_arb

Interface
REQ-001 Parameter WIDTH, default 8: width of the shared register and of each write-data port.
REQ-002 Parameter HOLD_MAX, default 4: number of granted cycles after which a grant becomes preemptible; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rc  input  1  reset; asynchronous, active-high.
REQ-005 Port req0  input  1  requester 0 request, level; held until released by the requester.
REQ-006 Port d0  input  WIDTH  requester 0 write data.
REQ-007 Port req1  input  1  requester 1 request, level.
REQ-008 Port d1  input  WIDTH  requester 1 write data.
REQ-009 Port gnt0  output  1  requester 0 owns the register; registered.
REQ-010 Port gnt1  output  1  requester 1 owns the register; registered.
REQ-011 Port q  output  WIDTH  shared register contents; registered.
REQ-012 Port busy  output  1  equals gnt0 OR gnt1.
REQ-013 Port sc  input  1  synchronous clear; present only when SYNC_CLR_EN is defined.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, G0 and G1; gnt0 is 1 only in G0 and gnt1 is 1 only in G1, so the grants are mutually exclusive.
REQ-015 IDLE, req0 only -> G0; req1 only -> G1; both -> grant the requester other than last-served; neither -> stay in IDLE.
REQ-016 Grant latency: a request sampled at edge N SHALL produce its gnt high after edge N, i.e. one cycle.
REQ-017 In G0, each edge with req0=1 SHALL load q <= d0; G1 behaves symmetrically with req1/d1; q SHALL hold its value in IDLE.
REQ-018 Hold counter: cleared on entry to G0/G1, incremented on each granted edge, saturating at HOLD_MAX.
REQ-019 Owner drops its req and other requests: switch directly to the other grant (G0<->G1) on the same edge, with no IDLE cycle.
REQ-020 Owner drops its req and no other request: return to IDLE; q is not written on that edge.
REQ-021 Counter == HOLD_MAX and the other requester is pending: preempt to the other grant on that edge; the current owner's write still occurs on that edge.
REQ-022 Counter == HOLD_MAX and no other request: remain in the grant, with the counter saturated.
REQ-023 last-served SHALL update to the owner whenever a grant state is left.

Reset
REQ-024 rc=1 SHALL immediately force state IDLE, gnt0=gnt1=0, busy=0, q=0, counter=0 and last-served=1, so that requester 0 wins the first tie.
REQ-025 Reset mid-grant SHALL abort the grant with no write; after rc deasserts, arbitration restarts from IDLE.

Configuration
REQ-026 With SYNC_CLR_EN defined, sc=1 at an edge SHALL set q=0 and force IDLE with counter=0, overriding any write and any transition; last-served is unchanged.
REQ-027 Without SYNC_CLR_EN, the sc port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-028 Package ff_bank_pkg SHALL hold the state enum (IDLE, G0, G1) and the default constants for WIDTH and HOLD_MAX.
REQ-029 Sub-module ff_word SHALL implement the WIDTH-bit register with async clear (rc), load enable, and the optional sync clear; ff_bank_arb holds the FSM and counter.

Verification (WIDTH=8, HOLD_MAX=4, clk period 40 ns)
REQ-030 Reset: rc=1 with req0=1 and d0=8'hFF -> q=8'h00, gnt0=gnt1=0; release rc -> gnt0=1 one cycle later, then q=8'hFF on the next edge.
REQ-031 Tie from reset: req0=req1=1 -> gnt0 first; req0 dropped -> gnt1 with no IDLE cycle; d1=8'h5A -> q=8'h5A.
REQ-032 Preemption: req0 held and req1 raised -> gnt0 lasts exactly 4 granted cycles, then gnt1=1 with the last d0 written; req1 alone held for 10 cycles -> gnt1 stays high.
REQ-033 Release to idle: owner drops req with no other request -> busy=0 next cycle, and q retains its last value.
REQ-034 Async reset mid-grant: rc pulsed for 5 ns between edges while in G1 -> q=0 and gnt1=0 at once; re-tie -> gnt0 wins.
REQ-035 SYNC_CLR_EN build: sc=1 during G0 with q=8'h3C -> q=8'h00 and gnt0=0 after that edge; non-macro build elaborates without sc.
